// File: rtl/core_id_dc_stage_pkg.sv
// Shared types and encoding constants for the instruction-decode stage.
// Includes the one-hot decode-info struct and the immediate-format enum.
package core_id_dc_stage_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_SD    = 7'b0100011;
    localparam logic [6:0] OPC_IA    = 7'b0010011;
    localparam logic [6:0] OPC_RA    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;

    localparam logic [6:0] ISTR_M_FUNCT7   = 7'b0000001;
    localparam logic [6:0] ISTR_SRA_FUNCT7 = 7'b0100000;

    localparam logic [31:0] ISTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] ISTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] ISTR_MRET   = 32'h3020_0073;
    localparam logic [31:0] ISTR_WFI    = 32'h1050_0073;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

    typedef struct packed {
        logic istr_is_lui, istr_is_auipc, istr_is_j, istr_is_jr;
        logic istr_is_br_beq, istr_is_br_bne, istr_is_br_blt, istr_is_br_bge, istr_is_br_bltu, istr_is_br_bgeu;
        logic istr_is_ld_lb, istr_is_ld_lh, istr_is_ld_lw, istr_is_ld_lbu, istr_is_ld_lhu;
        logic istr_is_sd_sb, istr_is_sd_sh, istr_is_sd_sw;
        logic istr_is_ia_addi, istr_is_ia_slti, istr_is_ia_sltiu, istr_is_ia_xori, istr_is_ia_ori, istr_is_ia_andi;
        logic istr_is_ia_slli, istr_is_ia_srli, istr_is_ia_srai;
        logic istr_is_ra_add, istr_is_ra_sub, istr_is_ra_sll, istr_is_ra_slt, istr_is_ra_sltu;
        logic istr_is_ra_xor, istr_is_ra_srl, istr_is_ra_sra, istr_is_ra_or, istr_is_ra_and;
        logic istr_is_fence;
        logic istr_is_ecall, istr_is_ebreak, istr_is_mret, istr_is_wfi;
        logic istr_is_csrrw, istr_is_csrrs, istr_is_csrrc, istr_is_csrrwi, istr_is_csrrsi, istr_is_csrrci;
        logic istr_is_mul, istr_is_mulh, istr_is_mulhsu, istr_is_mulhu;
        logic istr_is_div, istr_is_divu, istr_is_rem, istr_is_remu;
    } istr_dc2_info_t;

endpackage

// File: rtl/core_id_dc_stage_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
interface core_id_dc_stage_if import core_id_dc_stage_pkg::*; #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_istr;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [31:0]      out_istr;
    istr_dc2_info_t   out_dc_info;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] out_cnt;

    modport slave (
        input  flush, in_valid, in_istr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_istr, out_dc_info,
               out_rd, out_rs1, out_rs2, out_imm, out_illegal, out_cnt
    );

    modport master (
        output flush, in_valid, in_istr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_istr, out_dc_info,
               out_rd, out_rs1, out_rs2, out_imm, out_illegal, out_cnt
    );
endinterface

// File: rtl/core_id_istr_dc2.sv
// Combinational RV32I(+M) decoder: one-hot flags, register indices, immediate, illegal.
module core_id_istr_dc2 import core_id_dc_stage_pkg::*; #(
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CHK = 1'b1
) (
    input  logic [31:0]    istr,
    output istr_dc2_info_t dc_info,
    output logic [4:0]     rd,
    output logic [4:0]     rs1,
    output logic [4:0]     rs2,
    output logic [31:0]    imm,
    output logic           illegal
);
    logic [6:0]     opc, f7;
    logic [2:0]     f3;
    istr_dc2_info_t dc;
    logic           bad;
    imm_fmt_t       fmt;

    assign opc = istr[6:0];
    assign f3  = istr[14:12];
    assign f7  = istr[31:25];
    assign rd  = istr[11:7];
    assign rs1 = istr[19:15];
    assign rs2 = istr[24:20];

    always_comb begin
        dc  = '0;
        bad = 1'b0;
        fmt = IMM_NONE;
        case (opc)
            OPC_LUI:   begin dc.istr_is_lui = 1'b1;   fmt = IMM_U; end
            OPC_AUIPC: begin dc.istr_is_auipc = 1'b1; fmt = IMM_U; end
            OPC_JAL:   begin dc.istr_is_j = 1'b1;     fmt = IMM_J; end
            OPC_JALR:  begin dc.istr_is_jr = 1'b1;    fmt = IMM_I; end
            OPC_FENCE: dc.istr_is_fence = 1'b1;
            OPC_BR: begin
                fmt = IMM_B;
                case (f3)
                    3'b000:  dc.istr_is_br_beq  = 1'b1;
                    3'b001:  dc.istr_is_br_bne  = 1'b1;
                    3'b100:  dc.istr_is_br_blt  = 1'b1;
                    3'b101:  dc.istr_is_br_bge  = 1'b1;
                    3'b110:  dc.istr_is_br_bltu = 1'b1;
                    3'b111:  dc.istr_is_br_bgeu = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LD: begin
                fmt = IMM_I;
                case (f3)
                    3'b000:  dc.istr_is_ld_lb  = 1'b1;
                    3'b001:  dc.istr_is_ld_lh  = 1'b1;
                    3'b010:  dc.istr_is_ld_lw  = 1'b1;
                    3'b100:  dc.istr_is_ld_lbu = 1'b1;
                    3'b101:  dc.istr_is_ld_lhu = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OPC_SD: begin
                fmt = IMM_S;
                case (f3)
                    3'b000:  dc.istr_is_sd_sb = 1'b1;
                    3'b001:  dc.istr_is_sd_sh = 1'b1;
                    3'b010:  dc.istr_is_sd_sw = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OPC_IA: begin
                fmt = IMM_I;
                case (f3)
                    3'b000: dc.istr_is_ia_addi  = 1'b1;
                    3'b010: dc.istr_is_ia_slti  = 1'b1;
                    3'b011: dc.istr_is_ia_sltiu = 1'b1;
                    3'b100: dc.istr_is_ia_xori  = 1'b1;
                    3'b110: dc.istr_is_ia_ori   = 1'b1;
                    3'b111: dc.istr_is_ia_andi  = 1'b1;
                    3'b001: if (f7 == 7'd0) dc.istr_is_ia_slli = 1'b1; else bad = 1'b1;
                    default: begin
                        if (f7 == 7'd0)                 dc.istr_is_ia_srli = 1'b1;
                        else if (f7 == ISTR_SRA_FUNCT7) dc.istr_is_ia_srai = 1'b1;
                        else                            bad = 1'b1;
                    end
                endcase
            end
            OPC_RA: begin
                if (f7 == 7'd0) begin
                    case (f3)
                        3'b000:  dc.istr_is_ra_add  = 1'b1;
                        3'b001:  dc.istr_is_ra_sll  = 1'b1;
                        3'b010:  dc.istr_is_ra_slt  = 1'b1;
                        3'b011:  dc.istr_is_ra_sltu = 1'b1;
                        3'b100:  dc.istr_is_ra_xor  = 1'b1;
                        3'b101:  dc.istr_is_ra_srl  = 1'b1;
                        3'b110:  dc.istr_is_ra_or   = 1'b1;
                        default: dc.istr_is_ra_and  = 1'b1;
                    endcase
                end else if (f7 == ISTR_SRA_FUNCT7 && f3 == 3'b000) begin
                    dc.istr_is_ra_sub = 1'b1;
                end else if (f7 == ISTR_SRA_FUNCT7 && f3 == 3'b101) begin
                    dc.istr_is_ra_sra = 1'b1;
                end else if (f7 == ISTR_M_FUNCT7 && EN_M) begin
                    case (f3)
                        3'b000:  dc.istr_is_mul    = 1'b1;
                        3'b001:  dc.istr_is_mulh   = 1'b1;
                        3'b010:  dc.istr_is_mulhsu = 1'b1;
                        3'b011:  dc.istr_is_mulhu  = 1'b1;
                        3'b100:  dc.istr_is_div    = 1'b1;
                        3'b101:  dc.istr_is_divu   = 1'b1;
                        3'b110:  dc.istr_is_rem    = 1'b1;
                        default: dc.istr_is_remu   = 1'b1;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_SYS: begin
                fmt = IMM_I;
                case (f3)
                    3'b000: begin
                        case (istr)
                            ISTR_ECALL:  dc.istr_is_ecall  = 1'b1;
                            ISTR_EBREAK: dc.istr_is_ebreak = 1'b1;
                            ISTR_MRET:   dc.istr_is_mret   = 1'b1;
                            ISTR_WFI:    dc.istr_is_wfi    = 1'b1;
                            default:     bad = 1'b1;
                        endcase
                    end
                    3'b001:  dc.istr_is_csrrw  = 1'b1;
                    3'b010:  dc.istr_is_csrrs  = 1'b1;
                    3'b011:  dc.istr_is_csrrc  = 1'b1;
                    3'b101:  dc.istr_is_csrrwi = 1'b1;
                    3'b110:  dc.istr_is_csrrsi = 1'b1;
                    3'b111:  dc.istr_is_csrrci = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase

        case (fmt)
            IMM_I:   imm = {{20{istr[31]}}, istr[31:20]};
            IMM_S:   imm = {{20{istr[31]}}, istr[31:25], istr[11:7]};
            IMM_B:   imm = {{19{istr[31]}}, istr[31], istr[7], istr[30:25], istr[11:8], 1'b0};
            IMM_U:   imm = {istr[31:12], 12'h000};
            IMM_J:   imm = {{11{istr[31]}}, istr[31], istr[19:12], istr[20], istr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase

        // The consumer traps on illegal, so its flags are cleared to avoid side effects.
        illegal = (opc[1:0] != 2'b11) || (EN_CHK && bad);
        dc_info = illegal ? '0 : dc;
    end
endmodule

// File: rtl/core_id_dc_stage.sv
// Decode stage: decodes each fetched instruction and buffers it in a DEPTH-entry FIFO.
module core_id_dc_stage import core_id_dc_stage_pkg::*; #(
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2,
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CHK = 1'b1
) (
    input logic               clk,
    input logic               rst,
    core_id_dc_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]    istr;
        logic [PC_W-1:0] pc;
        istr_dc2_info_t dc_info;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [31:0]    imm;
        logic           illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    entry_t           wr_entry, head;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    core_id_istr_dc2 #(.EN_M(EN_M), .EN_CHK(EN_CHK)) u_dc (
        .istr    (bus.in_istr),
        .dc_info (wr_entry.dc_info),
        .rd      (wr_entry.rd),
        .rs1     (wr_entry.rs1),
        .rs2     (wr_entry.rs2),
        .imm     (wr_entry.imm),
        .illegal (wr_entry.illegal)
    );
    assign wr_entry.istr = bus.in_istr;
    assign wr_entry.pc   = bus.in_pc;

    assign bus.in_ready  = (cnt_q != FULL);
    assign bus.out_valid = (cnt_q != '0);
    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset; it is only observed behind out_valid.
    always_ff @(posedge clk) mem_q <= mem_d;

    assign head            = mem_q[rd_ptr_q];
    assign bus.out_pc      = head.pc;
    assign bus.out_istr    = head.istr;
    assign bus.out_dc_info = head.dc_info;
    assign bus.out_rd      = head.rd;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_imm     = head.imm;
    assign bus.out_illegal = head.illegal;
    assign bus.out_cnt     = cnt_q;
endmodule
